ps2_keys: RTL and testbench
===========================

PS2_KEYS -- requirements
Module: ps2_keys

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal pclk samples required before filtered ps2_clk changes.
REQ-002 SHALL have parameter TIMEOUT, default 32500: pclk cycles without a ps2_clk falling edge before a frame in progress is aborted (500 us at 65 MHz).
REQ-003 SHALL have port pclk  input  1  system clock; single clock domain for all logic.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock from keyboard.
REQ-006 SHALL have port ps2_data  input  1  asynchronous PS/2 data from keyboard.
REQ-007 SHALL have port key  output  4  registered held-key vector: bit0 up, bit1 down, bit2 left, bit3 right; feeds the car controller directly.
REQ-008 SHALL have port rx_byte  output  8  last correctly received scan byte.
REQ-009 SHALL have port rx_valid  output  1  one-cycle strobe, rx_byte updated.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe on parity, stop or timeout error.

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer clocked by pclk.
REQ-012 SHALL filter synchronized ps2_clk: filtered level changes only after FILTER_LEN consecutive samples at the new level; a falling edge is the 1-cycle event filtered 1->0.
REQ-013 SHALL sample synchronized ps2_data only on filtered falling edges.
REQ-014 SHALL implement FSM IDLE -> DATA -> PARITY -> STOP -> IDLE; IDLE leaves only on sampled start bit 0; sampled 1 in IDLE is ignored.
REQ-015 SHALL shift 8 data bits LSB first in DATA, using a 3-bit counter wrapping 7->0 on exit.
REQ-016 SHALL check odd parity over data+parity bit and stop bit = 1; any failure discards the byte, pulses frame_err, returns to IDLE.
REQ-017 SHALL, in any non-IDLE state, count pclk cycles since the last falling edge; reaching TIMEOUT aborts to IDLE, pulses frame_err, clears ext/brk flags.
REQ-018 SHALL, on a valid stop bit, load rx_byte and assert rx_valid in the next cycle (1-cycle latency from the stop-bit sample).
REQ-019 SHALL decode bytes: 0xE0 sets ext; 0xF0 sets brk; any other byte is a key code, after which ext and brk are cleared in the same cycle.
REQ-020 SHALL map ext codes 0x75 up, 0x72 down, 0x6B left, 0x74 right; matching make sets, break clears the bit; key updates in the same cycle as rx_valid.
REQ-021 SHALL ignore unmapped codes, non-ext arrow codes (keypad 8/2/4/6) and typematic repeats (make of held key leaves key unchanged; break of released key is a no-op).
REQ-022 SHALL clear all key bits and flags on byte 0x00 or 0xFF (keyboard overrun).
REQ-023 SHALL allow multiple key bits set simultaneously; key is never gated to one-hot (consumer treats multi-hot as no key).

Reset
REQ-024 SHALL on rst: key=0, rx_byte=0, rx_valid=0, frame_err=0, FSM=IDLE, counters=0, ext=brk=0, synchronizers and filter=1.
REQ-025 SHALL abort a frame in progress on rst with no rx_valid or frame_err pulse; the following frame is received normally.

Configuration
REQ-026 SHALL, with KEY_WASD_EN defined, also map non-ext codes 0x1D up, 0x1B down, 0x1C left, 0x23 right onto the same key bits (held state ORed per source, each released independently).
REQ-027 SHALL, without KEY_WASD_EN, treat 0x1D/0x1B/0x1C/0x23 as unmapped and contain no WASD state.

Verification
REQ-028 Frame E0, 75 at 12.5 kHz -> two rx_valid pulses, rx_byte 0xE0 then 0x75, key=4'b0001.
REQ-029 Key held (E0 75), then E0 F0 75 -> key returns 4'b0000; E0 75 repeated x5 in between -> key stays 4'b0001.
REQ-030 Byte 0x6B with bad parity -> frame_err pulse, no rx_valid, key unchanged; next valid E0 6B -> key=4'b0100.
REQ-031 Stop after 4 data bits, idle 32500 cycles -> frame_err pulse, FSM IDLE; next E0 74 -> key=4'b1000.
REQ-032 1-cycle ps2_clk glitches (width < FILTER_LEN) during idle -> no bit sampled, no strobes; rst mid-frame -> all outputs 0.
REQ-033 With KEY_WASD_EN: 1D make, E0 75 make, 1D break -> key=4'b0001 until E0 F0 75 -> 4'b0000.

Source files
------------

// File: rtl/ps2_keys.sv
// ps2_keys: PS/2 keyboard receiver and arrow-key decoder.
//
// The keyboard's clock and data lines are synchronized into pclk. The clock
// line is then debounced by a level filter. Data is sampled on filtered
// falling edges and framed as start, 8 data bits (LSB first), odd parity and
// stop. Good bytes are decoded into a held-key vector for the car controller:
// bit0 up, bit1 down, bit2 left, bit3 right.
//
// Build option: define KEY_WASD_EN to also map the W/S/A/D make/break codes
// (0x1D/0x1B/0x1C/0x23) onto the same key bits. Each source holds its own
// state and the two are ORed, so each source releases its bit on its own.
//
// Output strobe semantics: rx_valid is a one-cycle strobe and there is no
// ready. In the cycle rx_valid is high, rx_byte holds the new byte and key
// already reflects it. frame_err is a one-cycle strobe on a parity, stop or
// timeout failure. fsm_state exposes the frame FSM for debug:
// 0 idle, 1 data, 2 parity, 3 stop.
`timescale 1ns/1ps

module ps2_keys #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 32500
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [1:0] fsm_state
);

  // Widths sized so the terminal counts fit without truncation.
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronizer and filter state.
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          fall_edge;
  logic          data_smp;

  // Frame FSM state.
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  // Per-byte decode events.
  logic          byte_ok;
  logic          to_abort;

  // Decoder state and next-state values.
  logic          ext, brk;
  logic          ext_nxt, brk_nxt;
  logic [3:0]    key_ext, key_ext_nxt;
`ifdef KEY_WASD_EN
  logic [3:0]    key_wasd, key_wasd_nxt;
`endif

  // Two-flop synchronizers. Both lines idle high on reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock filter. The level flips only after FILTER_LEN consecutive samples
  // at the new level. A falling edge becomes a one-cycle event, and data is
  // captured together with it.
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_filt  <= 1'b1;
      flt_cnt   <= '0;
      fall_edge <= 1'b0;
      data_smp  <= 1'b1;
    end else begin
      fall_edge <= 1'b0;
      if (clk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_filt  <= clk_s2;
        flt_cnt   <= '0;
        fall_edge <= clk_filt;
        data_smp  <= dat_s2;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // An abort fires in the TIMEOUT-th cycle after the last falling edge. A
  // byte is good when the stop bit is 1 and the data+parity parity is odd.
  assign to_abort = (state != S_IDLE) && !fall_edge && (to_cnt == TO_LAST);
  assign byte_ok  = fall_edge && (state == S_STOP) && data_smp &&
                    (^{shreg, par_bit});

  // Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE, with a registered
  // error strobe and an inactivity timeout.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if ((state == S_IDLE) || fall_edge) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (to_abort) begin
        state     <= S_IDLE;
        bit_cnt   <= 3'd0;
        frame_err <= 1'b1;
      end else if (fall_edge) begin
        case (state)
          S_IDLE: begin
            // A sampled 1 here is line noise or the tail of a frame.
            if (!data_smp) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg   <= {data_smp, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_bit <= data_smp;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (!byte_ok) begin
              frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign fsm_state = state;

  // Received byte register and its one-cycle valid strobe.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rx_byte  <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= byte_ok;
      if (byte_ok) begin
        rx_byte <= shreg;
      end
    end
  end

  // Scan-code decode. E0 and F0 are prefixes. Any other byte is a key code
  // and consumes both prefixes. 00/FF signal a keyboard overrun and drop
  // every held key. A make of a held key, or a break of a released key,
  // rewrites the same value, so typematic repeats are harmless.
  always_comb begin
    ext_nxt      = ext;
    brk_nxt      = brk;
    key_ext_nxt  = key_ext;
`ifdef KEY_WASD_EN
    key_wasd_nxt = key_wasd;
`endif
    if (to_abort) begin
      ext_nxt = 1'b0;
      brk_nxt = 1'b0;
    end else if (byte_ok) begin
      case (shreg)
        8'hE0: ext_nxt = 1'b1;
        8'hF0: brk_nxt = 1'b1;
        8'h00, 8'hFF: begin
          ext_nxt      = 1'b0;
          brk_nxt      = 1'b0;
          key_ext_nxt  = 4'b0000;
`ifdef KEY_WASD_EN
          key_wasd_nxt = 4'b0000;
`endif
        end
        default: begin
          if (ext) begin
            case (shreg)
              8'h75:   key_ext_nxt[0] = ~brk;
              8'h72:   key_ext_nxt[1] = ~brk;
              8'h6B:   key_ext_nxt[2] = ~brk;
              8'h74:   key_ext_nxt[3] = ~brk;
              default: ;
            endcase
          end
`ifdef KEY_WASD_EN
          else begin
            case (shreg)
              8'h1D:   key_wasd_nxt[0] = ~brk;
              8'h1B:   key_wasd_nxt[1] = ~brk;
              8'h1C:   key_wasd_nxt[2] = ~brk;
              8'h23:   key_wasd_nxt[3] = ~brk;
              default: ;
            endcase
          end
`endif
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end
      endcase
    end
  end

  // Decoder registers. key is loaded in the same edge as rx_valid, so the
  // two change together.
  always_ff @(posedge pclk) begin
    if (rst) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      key_ext  <= 4'b0000;
`ifdef KEY_WASD_EN
      key_wasd <= 4'b0000;
`endif
      key      <= 4'b0000;
    end else begin
      ext      <= ext_nxt;
      brk      <= brk_nxt;
      key_ext  <= key_ext_nxt;
`ifdef KEY_WASD_EN
      key_wasd <= key_wasd_nxt;
      key      <= key_ext_nxt | key_wasd_nxt;
`else
      key      <= key_ext_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_keys.sv
// tb_ps2_keys: bench for ps2_keys. It drives PS/2 frames and keeps a queue of
// expected bytes. A vector table holds scan-code sequences and the key state
// each should leave. Hand-written sequences cover the error, timeout, glitch
// and reset corner cases.
`timescale 1ns/1ps

module tb_ps2_keys;

  localparam int HALF    = 20;     // pclk cycles per PS/2 clock half period
  localparam int TIMEOUT = 32500;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [1:0] fsm_state;

  int checks = 0;
  int failures = 0;
  int err_exp = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    int          n;
    logic [23:0] bytes;
    logic [3:0]  exp_key;
  } vec_t;

  vec_t tbl[16];

  ps2_keys dut (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .fsm_state (fsm_state)
  );

  // Clock.
  always #5 pclk = ~pclk;

  // Output monitor, sampling on the inactive edge.
  always @(negedge pclk) begin
    if (rx_valid) got_q.push_back(rx_byte);
    if (frame_err) err_seen = err_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (!bad_par && !bad_stop) exp_q.push_back(b);
    else err_exp++;
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    idle(10);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  // Compare every byte the DUT produced against the scoreboard queue.
  task automatic drain();
    logic [7:0] got;
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", got);
      end else begin
        check("rx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
      end
    end
    check("rx_missing", exp_q.size(), 0);
    check("frame_err_count", err_seen, err_exp);
  endtask

  task automatic send_seq(input int n, input logic [23:0] bytes, input logic [3:0] exp_key,
                          input string name);
    for (int i = 0; i < n; i++) send_frame(bytes[23 - 8*i -: 8], 1'b0, 1'b0);
    idle(5);
    drain();
    check(name, {28'd0, key}, {28'd0, exp_key});
  endtask

  initial begin
    tbl[0]  = '{2, 24'hE07500, 4'b0001};
    tbl[1]  = '{2, 24'hE07200, 4'b0011};
    tbl[2]  = '{1, 24'h6B0000, 4'b0011};
    tbl[3]  = '{2, 24'hE06B00, 4'b0111};
    tbl[4]  = '{3, 24'hE0F072, 4'b0101};
    tbl[5]  = '{3, 24'hE0F072, 4'b0101};
    tbl[6]  = '{2, 24'hE07400, 4'b1101};
    tbl[7]  = '{3, 24'hE0F075, 4'b1100};
    tbl[8]  = '{3, 24'hE01175, 4'b1100};
    tbl[9]  = '{2, 24'hF07400, 4'b1100};
    tbl[10] = '{2, 24'hE07200, 4'b1110};
    tbl[11] = '{1, 24'hFF0000, 4'b0000};
    tbl[12] = '{2, 24'hE06B00, 4'b0100};
    tbl[13] = '{1, 24'h000000, 4'b0000};
    tbl[14] = '{3, 24'hE0F06B, 4'b0000};
    tbl[15] = '{2, 24'hE07500, 4'b0001};

    // Reset state.
    idle(4);
    check("reset_key", {28'd0, key}, 0);
    check("reset_rx_byte", {24'd0, rx_byte}, 0);
    check("reset_rx_valid", {31'd0, rx_valid}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_fsm", {30'd0, fsm_state}, 0);
    rst = 1'b0;
    idle(20);

    // Table-driven scan-code sequences.
    for (int i = 0; i < 16; i++) send_seq(tbl[i].n, tbl[i].bytes, tbl[i].exp_key, "table_key");

    // Typematic repeats while up is held, then the release.
    for (int i = 0; i < 5; i++) send_seq(2, 24'hE07500, 4'b0001, "repeat_key");
    send_seq(3, 24'hE0F075, 4'b0000, "release_key");

    // Bad parity and bad stop bit.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b1, 1'b0);
    idle(5);
    drain();
    check("bad_parity_key", {28'd0, key}, 0);
    send_seq(2, 24'hE06B00, 4'b0100, "after_parity_key");
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b1);
    idle(5);
    drain();
    check("bad_stop_key", {28'd0, key}, 4'b0100);
    send_seq(3, 24'hE0F06B, 4'b0000, "after_stop_key");

    // Timeout: E0 arms ext, then a frame stalls after 4 data bits.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_partial(4);
    idle(TIMEOUT - 100);
    check("timeout_early_fsm", {31'd0, fsm_state != 2'd0}, 1);
    check("timeout_early_err", err_seen, err_exp);
    err_exp++;
    idle(200);
    check("timeout_fsm", {30'd0, fsm_state}, 0);
    drain();
    send_seq(1, 24'h740000, 4'b0000, "timeout_ext_cleared");
    send_seq(2, 24'hE07400, 4'b1000, "after_timeout_key");

    // Clock glitches shorter than the filter, with data held low.
    ps2_data = 1'b0;
    for (int w = 1; w <= 7; w++) begin
      ps2_clk = 1'b0;
      idle(w);
      ps2_clk = 1'b1;
      idle(20);
    end
    ps2_data = 1'b1;
    check("glitch_fsm", {30'd0, fsm_state}, 0);
    // A full clock pulse with data high must be ignored while idle.
    ps2_bit(1'b1);
    idle(20);
    check("idle_one_fsm", {30'd0, fsm_state}, 0);
    drain();
    send_seq(3, 24'hE0F074, 4'b0000, "after_glitch_key");

    // Reset in the middle of a frame.
    send_seq(2, 24'hE07200, 4'b0010, "pre_reset_key");
    send_partial(3);
    rst = 1'b1;
    idle(3);
    check("midrst_key", {28'd0, key}, 0);
    check("midrst_rx_byte", {24'd0, rx_byte}, 0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 0);
    check("midrst_frame_err", {31'd0, frame_err}, 0);
    check("midrst_fsm", {30'd0, fsm_state}, 0);
    rst = 1'b0;
    idle(500);
    drain();
    send_seq(2, 24'hE07500, 4'b0001, "after_reset_key");
    send_seq(3, 24'hE0F075, 4'b0000, "after_reset_release");

`ifdef KEY_WASD_EN
    send_seq(1, 24'h1D0000, 4'b0001, "wasd_w_make");
    send_seq(2, 24'hE07500, 4'b0001, "wasd_up_make");
    send_seq(2, 24'hF01D00, 4'b0001, "wasd_w_break");
    send_seq(3, 24'hE0F075, 4'b0000, "wasd_up_break");
    send_seq(2, 24'h1C2300, 4'b1100, "wasd_ad_make");
    send_seq(2, 24'hF01C00, 4'b1000, "wasd_a_break");
    send_seq(1, 24'hFF0000, 4'b0000, "wasd_overrun");
`else
    send_seq(2, 24'h1D1C00, 4'b0000, "no_wasd_make");
    send_seq(2, 24'h1B2300, 4'b0000, "no_wasd_make2");
`endif

    idle(20);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
